// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared ALU constants: word width, ALUOp codes, requester id encoding
package alu_arbiter_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int ALU_OP_W   = 5;

    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t ALUOP_NOP  = 5'b00000;
    localparam alu_op_t ALUOP_ADDU = 5'b00001;
    localparam alu_op_t ALUOP_SUBU = 5'b00010;
    localparam alu_op_t ALUOP_AND  = 5'b00011;
    localparam alu_op_t ALUOP_OR   = 5'b00100;
    localparam alu_op_t ALUOP_XOR  = 5'b00101;
    localparam alu_op_t ALUOP_NOR  = 5'b00110;
    localparam alu_op_t ALUOP_SLT  = 5'b00111;
    localparam alu_op_t ALUOP_SLL  = 5'b01000;
    localparam alu_op_t ALUOP_SRL  = 5'b01001;

    localparam int REQ_ID_W = 1;

    typedef logic [REQ_ID_W-1:0] req_id_t;

    // Requester 0 is the EX stage, requester 1 the branch/compare unit
    localparam req_id_t REQ_EX = 1'b0;
    localparam req_id_t REQ_BR = 1'b1;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, ALU-side and response signal bundle for alu_arbiter
interface alu_arbiter_if #(
    parameter int WORD_WIDTH = alu_arbiter_pkg::WORD_WIDTH
);
    import alu_arbiter_pkg::*;

    logic                  req0_valid;
    logic                  req0_ready;
    logic [WORD_WIDTH-1:0] req0_a;
    logic [WORD_WIDTH-1:0] req0_b;
    alu_op_t               req0_op;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [WORD_WIDTH-1:0] req1_a;
    logic [WORD_WIDTH-1:0] req1_b;
    alu_op_t               req1_op;

    logic [WORD_WIDTH-1:0] alu_in_a;
    logic [WORD_WIDTH-1:0] alu_in_b;
    alu_op_t               alu_op;
    logic [WORD_WIDTH-1:0] alu_out;

    logic                  rsp_valid;
    logic                  rsp_ready;
    req_id_t               rsp_id;
    logic [WORD_WIDTH-1:0] rsp_data;
    logic                  rsp_zero;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_out, rsp_ready,
        output req0_ready, req1_ready,
        output alu_in_a, alu_in_b, alu_op,
        output rsp_valid, rsp_id, rsp_data, rsp_zero
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_out, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_in_a, alu_in_b, alu_op,
        input  rsp_valid, rsp_id, rsp_data, rsp_zero
    );

endinterface

// File: rtl/alu_rr_arb2.sv
// rtl/alu_rr_arb2.sv - 2-way grant logic; round-robin, or fixed priority with ALU_ARB_FIXED_PRIO_EN
module alu_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic valid0,
    input  logic valid1,
    input  logic load,
    output logic pick0,
    output logic pick1
);
    import alu_arbiter_pkg::*;

    // pickN never looks at validN so the derived ready has no self-dependency
`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_fixed;

    assign unused_fixed = ^{clk, rst_n, load, valid1};
    assign pick0        = 1'b1;
    assign pick1        = !valid0;
`else
    req_id_t last_grant;

    assign pick0 = !valid1 || (last_grant == REQ_BR);
    assign pick1 = !valid0 || (last_grant == REQ_EX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= REQ_BR;
        end else if (load && valid0 && pick0) begin
            last_grant <= REQ_EX;
        end else if (load && valid1 && pick1) begin
            last_grant <= REQ_BR;
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester ALU arbiter with issue (S1) and response (S2) stages; option ALU_ARB_FIXED_PRIO_EN
module alu_arbiter #(
    parameter int WORD_WIDTH = alu_arbiter_pkg::WORD_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);
    import alu_arbiter_pkg::*;

    logic                  s1_valid;
    req_id_t               s1_id;
    logic [WORD_WIDTH-1:0] s1_a;
    logic [WORD_WIDTH-1:0] s1_b;
    alu_op_t               s1_op;

    logic                  rsp_valid_q;
    req_id_t               rsp_id_q;
    logic [WORD_WIDTH-1:0] rsp_data_q;
    logic                  rsp_zero_q;

    logic s2_load;
    logic s1_load;
    logic pick0;
    logic pick1;
    logic acc0;
    logic acc1;

    // S1 may refill in the same cycle it drains into S2
    assign s2_load = s1_valid && (!rsp_valid_q || bus.rsp_ready);
    assign s1_load = !s1_valid || s2_load;

    alu_rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid0 (bus.req0_valid),
        .valid1 (bus.req1_valid),
        .load   (s1_load),
        .pick0  (pick0),
        .pick1  (pick1)
    );

    assign bus.req0_ready = s1_load && pick0;
    assign bus.req1_ready = s1_load && pick1;
    assign acc0           = bus.req0_valid && bus.req0_ready;
    assign acc1           = bus.req1_valid && bus.req1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_id    <= REQ_EX;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= ALUOP_NOP;
        end else if (acc0) begin
            s1_valid <= 1'b1;
            s1_id    <= REQ_EX;
            s1_a     <= bus.req0_a;
            s1_b     <= bus.req0_b;
            s1_op    <= bus.req0_op;
        end else if (acc1) begin
            s1_valid <= 1'b1;
            s1_id    <= REQ_BR;
            s1_a     <= bus.req1_a;
            s1_b     <= bus.req1_b;
            s1_op    <= bus.req1_op;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= REQ_EX;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
        end else if (s2_load) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= s1_id;
            rsp_data_q  <= bus.alu_out;
            rsp_zero_q  <= (bus.alu_out == '0);
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // Stale operands stay on the ALU inputs; the opcode is forced to NOP when empty
    assign bus.alu_in_a  = s1_a;
    assign bus.alu_in_b  = s1_b;
    assign bus.alu_op    = s1_valid ? s1_op : ALUOP_NOP;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter (both build options)
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int W = 32;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   n_acc = 0;
    int   n_rsp = 0;

    alu_arbiter_if #(.WORD_WIDTH(W)) bus ();

    alu_arbiter #(.WORD_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        case (op)
            ALUOP_ADDU: return a + b;
            ALUOP_SUBU: return a - b;
            ALUOP_AND:  return a & b;
            ALUOP_OR:   return a | b;
            ALUOP_XOR:  return a ^ b;
            default:    return 32'd0;
        endcase
    endfunction

    always_comb bus.alu_out = alu_ref(bus.alu_in_a, bus.alu_in_b, bus.alu_op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                n_rsp++;
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("sb_id", 32'(bus.rsp_id), 32'(sb_e.id));
                    check("sb_data", bus.rsp_data, sb_e.data);
                    check("sb_zero", 32'(bus.rsp_zero), 32'(sb_e.data == 32'd0));
                end
            end
            if (bus.req0_valid && bus.req0_ready) begin
                sb_q.push_back({1'b0, alu_ref(bus.req0_a, bus.req0_b, bus.req0_op)});
                n_acc++;
            end else if (bus.req1_valid && bus.req1_ready) begin
                sb_q.push_back({1'b1, alu_ref(bus.req1_a, bus.req1_b, bus.req1_op)});
                n_acc++;
            end
        end
    end

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        logic [31:0] exp_data;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[7];

    task automatic drive(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        if (id) begin
            bus.req1_valid = 1'b1;
            bus.req1_a     = a;
            bus.req1_b     = b;
            bus.req1_op    = op;
        end else begin
            bus.req0_valid = 1'b1;
            bus.req0_a     = a;
            bus.req0_b     = b;
            bus.req0_op    = op;
        end
    endtask

    task automatic idle();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic exp0;

        vecs[0] = '{1'b0, 32'd5,          32'd7,          ALUOP_ADDU, 32'd12,         1'b0};
        vecs[1] = '{1'b1, 32'h0000_00F0,  32'h0000_000F,  ALUOP_OR,   32'h0000_00FF,  1'b0};
        vecs[2] = '{1'b0, 32'd9,          32'd9,          ALUOP_SUBU, 32'd0,          1'b1};
        vecs[3] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          ALUOP_ADDU, 32'd0,          1'b1};
        vecs[4] = '{1'b1, 32'h0000_FF00,  32'h0000_0FF0,  ALUOP_AND,  32'h0000_0F00,  1'b0};
        vecs[5] = '{1'b0, 32'h0000_000A,  32'h0000_0006,  ALUOP_XOR,  32'h0000_000C,  1'b0};
        vecs[6] = '{1'b1, 32'd3,          32'd4,          5'b11111,   32'd0,          1'b1};

        idle();
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = ALUOP_NOP;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = ALUOP_NOP;
        bus.rsp_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
        check("rst_rsp_data",  bus.rsp_data,       32'd0);
        check("rst_rsp_zero",  32'(bus.rsp_zero),  32'd0);
        check("rst_alu_op",    32'(bus.alu_op),    32'd0);
        check("rst_alu_in_a",  bus.alu_in_a,       32'd0);
        check("rst_alu_in_b",  bus.alu_in_b,       32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
            @(negedge clk);
            check("vec_ready", 32'(vecs[i].id ? bus.req1_ready : bus.req0_ready), 32'd1);
            @(posedge clk);
            #1 idle();
            @(negedge clk);
            check("vec_latency", 32'(bus.rsp_valid), 32'd0);
            @(posedge clk);
            @(negedge clk);
            check("vec_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("vec_rsp_data",  bus.rsp_data,       vecs[i].exp_data);
            check("vec_rsp_id",    32'(bus.rsp_id),    32'(vecs[i].id));
            check("vec_rsp_zero",  32'(bus.rsp_zero),  32'(vecs[i].exp_zero));
        end

        // Backpressure: S2 and S1 fill, both requesters blocked
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        drive(1'b0, 32'd1, 32'd2, ALUOP_ADDU);
        drive(1'b1, 32'h55, 32'hFF, ALUOP_XOR);
        repeat (3) @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("bp_req0_ready", 32'(bus.req0_ready), 32'd0);
            check("bp_req1_ready", 32'(bus.req1_ready), 32'd0);
            check("bp_rsp_valid",  32'(bus.rsp_valid),  32'd1);
            check("bp_rsp_data",   bus.rsp_data,        32'd3);
            check("bp_rsp_id",     32'(bus.rsp_id),     32'd0);
            @(posedge clk);
        end
        #1;
        idle();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_drain0_valid", 32'(bus.rsp_valid), 32'd1);
        @(negedge clk);
        check("bp_drain1_valid", 32'(bus.rsp_valid), 32'd1);
        check("bp_drain1_id",    32'(bus.rsp_id),    FIXED ? 32'd0 : 32'd1);
        check("bp_drain1_data",  bus.rsp_data,       FIXED ? 32'd3 : 32'hAA);
        @(negedge clk);
        check("bp_drain2_valid", 32'(bus.rsp_valid), 32'd0);
        check("bp_sb_empty",     32'(sb_q.size()),   32'd0);

        // Asynchronous reset with both stages occupied
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        drive(1'b0, 32'd9, 32'd9, ALUOP_SUBU);
        drive(1'b1, 32'hF0, 32'h0F, ALUOP_OR);
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("arst_alu_op",    32'(bus.alu_op),    32'(ALUOP_NOP));
        sb_q.delete();
        n_acc = 0;
        n_rsp = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;

        // Contention straight out of reset
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp0 = FIXED ? 1'b1 : (k % 2 == 0);
            check("cont_grant0", 32'(bus.req0_ready), 32'(exp0));
            check("cont_grant1", 32'(bus.req1_ready), 32'(!exp0));
            if (k == 2) begin
                check("cont_rsp0_valid", 32'(bus.rsp_valid), 32'd1);
                check("cont_rsp0_data",  bus.rsp_data,       32'd0);
                check("cont_rsp0_zero",  32'(bus.rsp_zero),  32'd1);
                check("cont_rsp0_id",    32'(bus.rsp_id),    32'd0);
            end
            if (k == 3) begin
                check("cont_rsp1_valid", 32'(bus.rsp_valid), 32'd1);
                check("cont_rsp1_data",  bus.rsp_data,       FIXED ? 32'd0 : 32'hFF);
                check("cont_rsp1_id",    32'(bus.rsp_id),    FIXED ? 32'd0 : 32'd1);
            end
            @(posedge clk);
            #1;
        end
        idle();

        for (int c = 0; c < 20 && (sb_q.size() != 0 || bus.rsp_valid); c++) @(negedge clk);
        @(negedge clk);
        check("drain_empty", 32'(sb_q.size()), 32'd0);
        check("acc_vs_rsp",  32'(n_rsp),       32'(n_acc));
        check("idle_alu_op", 32'(bus.alu_op),  32'(ALUOP_NOP));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and pipeline sequencer for the shared 32-bit ALU. Accepts operand/opcode requests from requester 0 (EX stage) and requester 1 (branch/compare unit) over valid/ready handshakes. Each winner is registered into an issue stage that drives the combinational ALU, and the ALU result is captured into a tagged response register with backpressure. It sits between the pipeline front-ends and the single ALU instance.

## Interface
- WORD_WIDTH, default `WORD_WIDTH (32): operand and result width.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req0_valid, req1_valid  in  1  request valid per requester.
- req0_ready, req1_ready  out  1  request accepted this cycle when high with valid.
- req0_a, req0_b, req1_a, req1_b  in  WORD_WIDTH  operands (inA, inB).
- req0_op, req1_op  in  5  ALUOp code.
- alu_in_a, alu_in_b  out  WORD_WIDTH  ALU operands.
- alu_op  out  5  ALU opcode; ALUOp_NOP (5'b00000) when the issue stage is empty.
- alu_out  in  WORD_WIDTH  combinational ALU result. The ALU zero port is not used.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester index that owns the response.
- rsp_data  out  WORD_WIDTH  registered ALU result.
- rsp_zero  out  1  high when rsp_data == 0.

## Operation
- Two register stages.
  - S1 (issue): s1_valid, s1_id, s1_a, s1_b, s1_op. Drives alu_in_a/alu_in_b/alu_op directly.
  - S2 (response): rsp_valid, rsp_id, rsp_data, rsp_zero.
- S2 loads when S1 is valid and S2 can load. S2 can load when !rsp_valid || rsp_ready.
  - Loads rsp_data <= alu_out, rsp_zero <= (alu_out == 0), rsp_id <= s1_id.
- S1 can load when !s1_valid or S1 advances into S2 in the same cycle.
- Arbitration is round-robin (default build).
  - A 1-bit pointer last_grant names the requester most recently accepted.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester != last_grant is granted.
- reqN_ready = granted_N && S1-can-load.
  - reqN_ready may depend on the other requester's valid but never on its own.
  - Requesters must hold valid/a/b/op stable until accepted.
- On acceptance: S1 loads the winner's operands and opcode, s1_id <= N, last_grant <= N. last_grant is unchanged in cycles with no acceptance.
- S1 empties (s1_valid <= 0) when it advances into S2 and nothing is accepted.
- rsp_valid clears on rsp_ready with no new load.
- Opcodes are passed through unchecked. Unsupported codes yield the ALU's default 0, so rsp_zero = 1.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - s1_valid, rsp_valid, rsp_id, rsp_data = 0.
  - rsp_zero = 0.
  - alu_in_a/alu_in_b = 0, alu_op = NOP.
  - last_grant = 1, so requester 0 wins the first contention.
- Reset mid-operation discards both in-flight entries with no response.
- Latency: a request accepted on edge E presents rsp_valid after edge E+1, provided S2 is free.
- Throughput: one request per cycle with no stall.
- Backpressure (rsp_valid && !rsp_ready):
  - S2 holds.
  - S1 holds if valid.
  - Both req_ready outputs are low when S1 is full.
- Simultaneous events:
  - rsp_ready with S1 valid: S2 reloads the same cycle with no bubble.
  - A new grant into a draining S1: accepted the same cycle.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 always wins when both are valid; last_grant is removed.
- Undefined: round-robin as above.
- Requester 1 starvation under continuous requester-0 traffic is expected behaviour when the macro is defined.

## Structure
- ALUOp codes, WORD_WIDTH, and the requester-id width/encoding belong in the shared constants package, next to the existing ALU control definitions.
- One sub-module: alu_rr_arb2, the 2-way grant logic. It has the pointer register and an ALU_ARB_FIXED_PRIO_EN bypass.
- S1/S2 staging stays in alu_arbiter.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- Single request: req0 ADDU a=5, b=7, rsp_ready=1. Expect rsp_valid two edges after acceptance, rsp_data=12, rsp_id=0, rsp_zero=0.
- Contention:
  - Stimulus: both valid every cycle; req0 SUBU 9-9, req1 OR 0xF0|0x0F.
  - Required response: grants alternate 0,1,0,1.
  - First response: rsp_data=0, rsp_zero=1.
  - Second response: rsp_data=0xFF, id=1.
- Backpressure: hold rsp_ready=0 for 3 cycles with both requesters valid. Expect S1 filled, both req_ready=0, rsp_data stable. On release, one response per cycle with no lost or duplicated ids.
- Unsupported op: req1 op=5'b11111. Expect rsp_data=0, rsp_zero=1, rsp_id=1.
- Async reset: assert rst_n low with S1 and S2 both valid. Expect rsp_valid=0 and alu_op=NOP immediately. After release, req0 wins the first contention.
- With ALU_ARB_FIXED_PRIO_EN: both requesters valid for 4 cycles. Expect req0_ready on every accepting cycle and req1_ready never.
